// File: rtl/cart_pkg.sv
// Shared types and constants for the 2600 cart ROM fetch path.
// SDRAM word layout and the fetch FSM state encoding.
package cart_pkg;

  localparam int SDRAM_W = 16;
  localparam int EVEN_LO = 0;
  localparam int ODD_LO  = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_e;

  function automatic logic [7:0] byte_sel(
    input logic [SDRAM_W-1:0] w,
    input logic               odd
  );
    return odd ? w[ODD_LO +: 8] : w[EVEN_LO +: 8];
  endfunction

endpackage

// File: rtl/cart_fetch_cache.sv
// Direct-mapped word cache for cart ROM fetches.
// Combinational lookup, synchronous fill and flush.
module cart_fetch_cache
  import cart_pkg::*;
#(
  parameter int LINES  = 4,
  parameter int ADDR_W = 19
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-2:0]  lk_wa,
  input  logic               fill_en,
  input  logic [ADDR_W-2:0]  fill_wa,
  input  logic [SDRAM_W-1:0] fill_data,
  input  logic               flush,
  output logic               hit,
  output logic [SDRAM_W-1:0] hit_word
);

  localparam int IDXW  = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 1 - IDXW;

  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [TAG_W-1:0]   tag_d  [LINES];
  logic [SDRAM_W-1:0] data_q [LINES];
  logic [SDRAM_W-1:0] data_d [LINES];
  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   valid_d;

  logic [IDXW-1:0]  lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDXW-1:0]  fl_idx;
  logic [TAG_W-1:0] fl_tag;

  assign lk_idx   = lk_wa[IDXW-1:0];
  assign lk_tag   = lk_wa[ADDR_W-2:IDXW];
  assign fl_idx   = fill_wa[IDXW-1:0];
  assign fl_tag   = fill_wa[ADDR_W-2:IDXW];
  assign hit      = valid_q[lk_idx] &&
                    (tag_q[lk_idx] == lk_tag);
  assign hit_word = data_q[lk_idx];

  // Next-state of the arrays: flush beats fill.
  always_comb begin
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (fill_en) begin
      tag_d[fl_idx]   = fl_tag;
      data_d[fl_idx]  = fill_data;
      valid_d[fl_idx] = 1'b1;
    end
  end

  // Array registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/cart_rom_fetch.sv
// Mapper byte reads to SDRAM word requests, with a word cache.
// Holds rom_do stable between lookups.
module cart_rom_fetch
  import cart_pkg::*;
#(
  parameter int LINES  = 4,
  parameter int ADDR_W = 19
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  rom_a,
  input  logic               rom_read,
  input  logic               flush,
  output logic [7:0]         rom_do,
  output logic               rom_valid,
  output logic               sdram_req,
  output logic [ADDR_W-2:0]  sdram_addr,
  input  logic               sdram_ack,
  input  logic [SDRAM_W-1:0] sdram_rdata
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pend_a_q, pend_a_d;
  logic [7:0]        rom_do_q, rom_do_d;
  logic              rom_valid_q, rom_valid_d;
  logic              req_q, req_d;
  logic [ADDR_W-2:0] addr_q, addr_d;
  logic              discard_q, discard_d;

  logic               hit;
  logic [SDRAM_W-1:0] hit_word;
  logic               fill_en;
  logic               c_flush;

  cart_fetch_cache #(
    .LINES  (LINES),
    .ADDR_W (ADDR_W)
  ) u_cache (
    .clk       (clk),
    .reset_n   (reset_n),
    .lk_wa     (rom_a[ADDR_W-1:1]),
    .fill_en   (fill_en),
    .fill_wa   (pend_a_q[ADDR_W-1:1]),
    .fill_data (sdram_rdata),
    .flush     (c_flush),
    .hit       (hit),
    .hit_word  (hit_word)
  );

  // Fetch FSM: the request is raised on the miss edge itself,
  // so REQ and WAIT both accept an ack.
  always_comb begin
    state_d     = state_q;
    pend_a_d    = pend_a_q;
    rom_do_d    = rom_do_q;
    rom_valid_d = rom_valid_q;
    req_d       = req_q;
    addr_d      = addr_q;
    discard_d   = discard_q;
    fill_en     = 1'b0;
    c_flush     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush) begin
          c_flush     = 1'b1;
          rom_valid_d = 1'b0;
        end else if (rom_read) begin
          if (hit) begin
            rom_do_d    = byte_sel(hit_word, rom_a[0]);
            rom_valid_d = 1'b1;
          end else begin
            pend_a_d    = rom_a;
            rom_valid_d = 1'b0;
            req_d       = 1'b1;
            addr_d      = rom_a[ADDR_W-1:1];
            state_d     = REQ;
          end
        end
      end
      REQ, WAIT: begin
        state_d = WAIT;
        if (flush) begin
          c_flush     = 1'b1;
          rom_valid_d = 1'b0;
          if (sdram_ack) begin
            req_d     = 1'b0;
            discard_d = 1'b0;
            state_d   = IDLE;
          end else begin
            discard_d = 1'b1;
          end
        end else if (sdram_ack) begin
          req_d     = 1'b0;
          discard_d = 1'b0;
          state_d   = IDLE;
          if (!discard_q) begin
            fill_en = 1'b1;
            if (rom_read && (rom_a != pend_a_q)) begin
              rom_valid_d = 1'b0;
            end else begin
              rom_do_d    = byte_sel(sdram_rdata,
                                     pend_a_q[0]);
              rom_valid_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pend_a_q    <= '0;
      rom_do_q    <= '0;
      rom_valid_q <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_a_q    <= pend_a_d;
      rom_do_q    <= rom_do_d;
      rom_valid_q <= rom_valid_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      discard_q   <= discard_d;
    end
  end

  assign rom_do     = rom_do_q;
  assign rom_valid  = rom_valid_q;
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

endmodule

// File: tb/tb_cart_rom_fetch.sv
// Directed and random checks of cart_rom_fetch against a
// line-level cache model kept in the bench.
module tb_cart_rom_fetch;

  localparam int LINES  = 4;
  localparam int ADDR_W = 19;
  localparam int IDXW   = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] rom_a = '0;
  logic              rom_read = 1'b0;
  logic              flush = 1'b0;
  logic [7:0]        rom_do;
  logic              rom_valid;
  logic              sdram_req;
  logic [ADDR_W-2:0] sdram_addr;
  logic              sdram_ack = 1'b0;
  logic [15:0]       sdram_rdata = '0;

  int n_assert = 0;
  int n_fail   = 0;

  bit          mvalid [LINES];
  int          mtag   [LINES];
  logic [15:0] mdata  [LINES];
  logic [7:0]  last_b;

  cart_rom_fetch #(
    .LINES  (LINES),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rom_a       (rom_a),
    .rom_read    (rom_read),
    .flush       (flush),
    .rom_do      (rom_do),
    .rom_valid   (rom_valid),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .sdram_rdata (sdram_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(
    input logic [15:0] w, input logic odd);
    logic [15:0] s;
    s = w >> (odd ? 8 : 0);
    return s[7:0];
  endfunction

  function automatic int m_idx(input logic [ADDR_W-1:0] a);
    return int'(a >> 1) % LINES;
  endfunction

  function automatic int m_tag(input logic [ADDR_W-1:0] a);
    return int'(a >> (IDXW + 1));
  endfunction

  function automatic bit m_hit(input logic [ADDR_W-1:0] a);
    return mvalid[m_idx(a)] && (mtag[m_idx(a)] == m_tag(a));
  endfunction

  task automatic m_fill(input logic [ADDR_W-1:0] a,
                        input logic [15:0] w);
    mvalid[m_idx(a)] = 1'b1;
    mtag[m_idx(a)]   = m_tag(a);
    mdata[m_idx(a)]  = w;
  endtask

  task automatic m_clear();
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a,
                         input int lat,
                         input logic [15:0] w);
    logic [31:0] wa;
    wa = 32'(a >> 1);
    rom_read = 1'b1;
    rom_a    = a;
    if (m_hit(a)) begin
      tick();
      last_b = exp_byte(mdata[m_idx(a)], a[0]);
      chk("hit_valid", 32'(rom_valid), 1);
      chk("hit_byte", 32'(rom_do), 32'(last_b));
      chk("hit_noreq", 32'(sdram_req), 0);
    end else begin
      tick();
      chk("miss_valid", 32'(rom_valid), 0);
      chk("miss_req", 32'(sdram_req), 1);
      chk("miss_addr", 32'(sdram_addr), wa);
      for (int i = 0; i < lat; i++) begin
        tick();
        chk("req_hold", 32'(sdram_req), 1);
        chk("addr_hold", 32'(sdram_addr), wa);
      end
      sdram_rdata = w;
      sdram_ack   = 1'b1;
      tick();
      sdram_ack = 1'b0;
      last_b = exp_byte(w, a[0]);
      chk("fill_req0", 32'(sdram_req), 0);
      chk("fill_valid", 32'(rom_valid), 1);
      chk("fill_byte", 32'(rom_do), 32'(last_b));
      m_fill(a, w);
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    logic [15:0]       w;
    m_clear();

    // reset state
    tick();
    tick();
    chk("rst_do", 32'(rom_do), 0);
    chk("rst_valid", 32'(rom_valid), 0);
    chk("rst_req", 32'(sdram_req), 0);
    chk("rst_addr", 32'(sdram_addr), 0);
    reset_n = 1'b1;
    tick();
    chk("idle_req", 32'(sdram_req), 0);

    // cold miss, then same-word hits
    do_read(19'h01234, 5, 16'hBEEF);
    chk("cold_addr_const", 32'(dut.sdram_addr), 32'h0091A);
    do_read(19'h01235, 0, 16'h0);
    chk("odd_be", 32'(rom_do), 32'hBE);
    do_read(19'h01234, 0, 16'h0);
    chk("even_ef", 32'(rom_do), 32'hEF);

    // conflict on one index
    do_read(19'h00000, 2, 16'(($urandom)));
    do_read(19'h00008, 1, 16'(($urandom)));
    do_read(19'h00000, 3, 16'(($urandom)));

    // address change while waiting
    rom_read = 1'b1;
    rom_a    = 19'h00100;
    tick();
    chk("chg_req", 32'(sdram_req), 1);
    chk("chg_addr", 32'(sdram_addr), 32'h80);
    tick();
    rom_a = 19'h00200;
    tick();
    tick();
    chk("chg_hold_req", 32'(sdram_req), 1);
    chk("chg_hold_addr", 32'(sdram_addr), 32'h80);
    w = 16'($urandom);
    sdram_rdata = w;
    sdram_ack   = 1'b1;
    tick();
    sdram_ack = 1'b0;
    chk("chg_valid0", 32'(rom_valid), 0);
    chk("chg_req0", 32'(sdram_req), 0);
    m_fill(19'h00100, w);
    do_read(19'h00200, 1, 16'($urandom));
    chk("chg_second", 32'(dut.sdram_addr), 32'h100);

    // flush while waiting
    a = 19'h05550;
    rom_a = a;
    tick();
    chk("fw_req", 32'(sdram_req), 1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    m_clear();
    chk("fw_valid0", 32'(rom_valid), 0);
    chk("fw_req_held", 32'(sdram_req), 1);
    sdram_rdata = 16'h1111;
    sdram_ack   = 1'b1;
    tick();
    sdram_ack = 1'b0;
    chk("fw_req0", 32'(sdram_req), 0);
    chk("fw_nofill", 32'(rom_valid), 0);
    do_read(a, 1, 16'($urandom));

    // flush and ack on the same edge
    a = 19'h06662;
    rom_a = a;
    tick();
    chk("fa_req", 32'(sdram_req), 1);
    flush       = 1'b1;
    sdram_ack   = 1'b1;
    sdram_rdata = 16'h2222;
    tick();
    flush     = 1'b0;
    sdram_ack = 1'b0;
    m_clear();
    chk("fa_req0", 32'(sdram_req), 0);
    chk("fa_valid0", 32'(rom_valid), 0);
    do_read(a, 0, 16'($urandom));

    // read and flush on the same edge
    flush = 1'b1;
    tick();
    flush = 1'b0;
    m_clear();
    chk("rf_valid0", 32'(rom_valid), 0);
    chk("rf_noreq", 32'(sdram_req), 0);
    do_read(a, 2, 16'($urandom));

    // random traffic over a small pool with high-bit tags
    for (int n = 0; n < 60; n++) begin
      a = 19'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) a[18] = 1'b1;
      do_read(a, $urandom_range(0, 3), 16'($urandom));
    end

    // outputs hold while rom_read is low
    rom_read = 1'b0;
    rom_a    = 19'($urandom);
    tick();
    tick();
    chk("hold_valid", 32'(rom_valid), 1);
    chk("hold_do", 32'(rom_do), 32'(last_b));
    chk("hold_noreq", 32'(sdram_req), 0);

    // reset while waiting, then a stray ack
    rom_read = 1'b1;
    rom_a    = 19'h07770;
    tick();
    chk("rw_req", 32'(sdram_req), 1);
    rom_read = 1'b0;
    reset_n  = 1'b0;
    tick();
    reset_n     = 1'b1;
    sdram_ack   = 1'b1;
    sdram_rdata = 16'($urandom);
    tick();
    sdram_ack = 1'b0;
    m_clear();
    chk("rw_req0", 32'(sdram_req), 0);
    chk("rw_do0", 32'(rom_do), 0);
    chk("rw_valid0", 32'(rom_valid), 0);
    chk("rw_addr0", 32'(sdram_addr), 0);
    do_read(19'h01234, 1, 16'($urandom));
    do_read(19'h07770, 0, 16'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
